demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- Registered, parametrised 1-to-CHANNELS stream demultiplexer with valid/ready handshaking on the input and on every output.
- Generalises the 1-bit two-way demux:
  - WIDTH-bit words
  - CHANNELS outputs
  - a broadcast mode
  - per-channel one-entry output buffers
  - counting of words dropped for an out-of-range select
- Sits between a single producer and several consumers, for example to fan bus writes out to peripheral ports.

Parameters:
- WIDTH, 16: data word width in bits.
- CHANNELS, 4: number of output channels; legal range 2..16.
- SEL_WIDTH, 2: width of inSelect; must satisfy 2^SEL_WIDTH >= CHANNELS.

Ports:
- clock  input  1  rising-edge clock for all state.
- resetN  input  1  synchronous, active-low reset.
- inValid  input  1  producer has a word.
- inReady  output  1  block can accept the presented word this cycle.
- inData  input  WIDTH  word to route.
- inSelect  input  SEL_WIDTH  target channel index.
- inBroadcast  input  1  1 = deliver the word to every channel; inSelect is ignored.
- outValid  output  CHANNELS  bit c: channel c buffer holds a word.
- outReady  input  CHANNELS  bit c: consumer c takes the word this cycle.
- outData  output  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]; reads 0 whenever outValid[c] = 0.
- dropCount  output  8  number of words discarded for an out-of-range select; saturates.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: on a rising clock edge with resetN = 0, the following are cleared, regardless of other inputs:
  - all outValid = 0
  - all buffers = 0
  - dropCount = 0
- Reset mid-operation: buffered words are discarded and no handshake completes on that edge.
- Input transfer occurs on an edge where inValid = 1 and inReady = 1.
- Output transfer on channel c occurs on an edge where outValid[c] = 1 and outReady[c] = 1.
- Per-channel free condition: free[c] = !outValid[c] | outReady[c]. A buffer being drained this cycle counts as free, so back-to-back words give full throughput.
- inReady is combinational from inSelect, inBroadcast, outValid and outReady. It must not depend on inValid.
  - inBroadcast = 1: inReady = AND of free[c] over all channels.
  - inBroadcast = 0, inSelect < CHANNELS: inReady = free[inSelect].
  - inBroadcast = 0, inSelect >= CHANNELS: inReady = 1.
- On an accepted word:
  - Unicast in-range: buffer[inSelect] <= inData and outValid[inSelect] <= 1.
  - Broadcast: every buffer <= inData and every outValid <= 1. All channels load on the same edge, so the broadcast is atomic and never partial.
  - Out-of-range unicast: the word is dropped, no outValid changes, and dropCount increments by 1, saturating at 255.
- Latency: a word accepted on edge N is visible on outValid/outData after edge N, i.e. one cycle.
- Simultaneous drain and load on the same channel at the same edge: the load wins, outValid stays 1, and the new data replaces the old. The old word counts as consumed.
- Drain with no load: outValid[c] <= 0 and the buffer clears to 0.
- Without a new transfer, outValid[c] and the data are held. Data must be stable while outValid = 1 and outReady = 0.
- Channel independence: a stalled channel blocks only words targeted at it, plus any broadcast. Other channels continue to drain.
- There is no internal ordering across channels.

Test Plan:
- Reset: hold resetN = 0 for 2 clocks while driving inValid = 1 -> outValid = 0000, outData all 0, dropCount = 0, no word accepted.
- Unicast with one-cycle latency: inData = 0xBEEF, inSelect = 2, inValid = 1, all outReady = 0 -> after 1 edge outValid = 0100 and channel-2 data = 0xBEEF. A second word to channel 2 sees inReady = 0 until outReady[2] = 1, then is accepted on the drain edge and outValid[2] stays 1 with the new data.
- Broadcast atomicity: channel 1 full and stalled, inBroadcast = 1, inData = 0x1234 -> inReady = 0 and no channel loads. Raise outReady[1] -> accepted, all four outValid = 1 with 0x1234 after 1 edge.
- Out-of-range drop: CHANNELS = 3, SEL_WIDTH = 2, inSelect = 3, 300 consecutive words -> inReady = 1 throughout, no outValid asserted, dropCount = 255 (saturated).
- Throughput and independence: stream 8 words alternating channels 0 and 3 with outReady = 1001, while channel 1 is held full and stalled -> one word accepted per cycle, outputs arrive in order per channel, channel 1 data unchanged.
- Reset mid-operation: three channels full, assert resetN = 0 for one edge -> all outValid = 0 and dropCount = 0 on the next cycle.

Source files
------------

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-CHANNELS stream demultiplexer with
// valid/ready handshakes, broadcast, per-channel one-entry output buffers
// and a saturating count of words dropped for an out-of-range select.
//
// Ports:
//   clock        rising-edge clock for all state
//   resetN       synchronous active-low reset
//   inValid      producer has a word
//   inReady      word on inData can be accepted this cycle (combinational)
//   inData       word to route
//   inSelect     target channel index
//   inBroadcast  deliver the word to every channel, inSelect ignored
//   outValid     bit c: channel c buffer holds a word
//   outReady     bit c: consumer c takes its word this cycle
//   outData      channel c at [c*WIDTH +: WIDTH], zero while outValid[c]=0
//   dropCount    words discarded for an out-of-range select, saturating
module demux_stream #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic [WIDTH-1:0]             inData,
    input  logic [SEL_WIDTH-1:0]         inSelect,
    input  logic                         inBroadcast,
    output logic [CHANNELS-1:0]          outValid,
    input  logic [CHANNELS-1:0]          outReady,
    output logic [CHANNELS*WIDTH-1:0]    outData,
    output logic [7:0]                   dropCount
);

    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Elaboration-time parameter sanity checks
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
        $error("demux_stream: CHANNELS must be in 2..16");
    end
    if ((2 ** SEL_WIDTH) < CHANNELS) begin : g_bad_sel_width
        $error("demux_stream: SEL_WIDTH too narrow for CHANNELS");
    end

    logic [CHANNELS-1:0]             valid_q, valid_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  data_q,  data_d;
    logic [DROP_W-1:0]               drop_q,  drop_d;

    logic [CHANNELS-1:0]             free_c;
    logic [CHANNELS-1:0]             sel_hit_c;
    logic [CHANNELS-1:0]             load_c;
    logic                            sel_in_range_c;
    logic                            accept_c;
    logic                            drop_c;

    // A buffer being drained this cycle can take a new word on the same edge
    assign free_c = ~valid_q | outReady;

    // One-hot decode of inSelect; all-zero when the select is out of range
    always_comb begin
        sel_hit_c = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (inSelect == SEL_WIDTH'(c)) begin
                sel_hit_c[c] = 1'b1;
            end
        end
    end

    assign sel_in_range_c = |sel_hit_c;

    // Ready must not look at inValid; out-of-range words are always sunk
    always_comb begin
        inReady = 1'b1;
        if (inBroadcast) begin
            inReady = &free_c;
        end else if (sel_in_range_c) begin
            inReady = |(sel_hit_c & free_c);
        end
    end

    assign accept_c = inValid & inReady;
    assign drop_c   = accept_c & ~inBroadcast & ~sel_in_range_c;

    // Broadcast loads every channel on the same edge, so it is never partial
    always_comb begin
        load_c = '0;
        if (accept_c) begin
            load_c = inBroadcast ? {CHANNELS{1'b1}} : sel_hit_c;
        end
    end

    // Per-channel buffer update: load beats drain, drain clears the data
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (load_c[c]) begin
                valid_d[c] = 1'b1;
                data_d[c]  = inData;
            end else if (valid_q[c] && outReady[c]) begin
                valid_d[c] = 1'b0;
                data_d[c]  = '0;
            end
        end
    end

    // Saturating drop counter
    always_comb begin
        drop_d = drop_q;
        if (drop_c && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetN) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign outValid  = valid_q;
    assign outData   = data_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus a random
// run compared against a behavioural model of the channel buffers.
module tb_demux_stream;

    localparam int unsigned W  = 16;
    localparam int unsigned NC = 4;

    logic clk;
    logic rst_n;

    // Four-channel instance
    logic            in_valid, in_ready, in_bc;
    logic [W-1:0]    in_data;
    logic [1:0]      in_sel;
    logic [NC-1:0]   out_valid, out_ready;
    logic [NC*W-1:0] out_data;
    logic [7:0]      drop_cnt;

    // Three-channel instance (select value 3 is out of range)
    logic            in_valid3, in_ready3, in_bc3;
    logic [W-1:0]    in_data3;
    logic [1:0]      in_sel3;
    logic [2:0]      out_valid3, out_ready3;
    logic [3*W-1:0]  out_data3;
    logic [7:0]      drop_cnt3;

    int n_checks;
    int n_fail;

    // Behavioural model of the four-channel instance
    logic         m_valid [NC];
    logic [W-1:0] m_data  [NC];
    int           m_drop;

    demux_stream #(.WIDTH(W), .CHANNELS(NC), .SEL_WIDTH(2)) dut (
        .clock(clk), .resetN(rst_n),
        .inValid(in_valid), .inReady(in_ready), .inData(in_data),
        .inSelect(in_sel), .inBroadcast(in_bc),
        .outValid(out_valid), .outReady(out_ready), .outData(out_data),
        .dropCount(drop_cnt)
    );

    demux_stream #(.WIDTH(W), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
        .clock(clk), .resetN(rst_n),
        .inValid(in_valid3), .inReady(in_ready3), .inData(in_data3),
        .inSelect(in_sel3), .inBroadcast(in_bc3),
        .outValid(out_valid3), .outReady(out_ready3), .outData(out_data3),
        .dropCount(drop_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ch(input int c);
        return out_data[c*W +: W];
    endfunction

    function automatic bit m_ready();
        bit r;
        if (in_bc) begin
            r = 1'b1;
            for (int c = 0; c < NC; c++) r = r & (!m_valid[c] || out_ready[c]);
        end else if (int'(in_sel) < NC) begin
            r = !m_valid[in_sel] || out_ready[in_sel];
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                m_valid[c] = 1'b0;
                m_data[c]  = '0;
            end
            m_drop = 0;
        end else begin
            acc = in_valid && m_ready();
            for (int c = 0; c < NC; c++) begin
                if (acc && (in_bc || int'(in_sel) == c)) begin
                    m_valid[c] = 1'b1;
                    m_data[c]  = in_data;
                end else if (m_valid[c] && out_ready[c]) begin
                    m_valid[c] = 1'b0;
                    m_data[c]  = '0;
                end
            end
            if (acc && !in_bc && int'(in_sel) >= NC && m_drop < 255) m_drop++;
        end
    endtask

    // Advance one clock; inputs are stable from here until the next edge
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_bc = 0; in_sel = 0; in_data = 0; out_ready = 0;
        in_valid3 = 0; in_bc3 = 0; in_sel3 = 0; in_data3 = 0; out_ready3 = 0;
    endtask

    task automatic drain_all();
        idle_inputs();
        out_ready = '1;
        out_ready3 = '1;
        step();
        out_ready = '0;
        out_ready3 = '0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        in_valid = 1; in_sel = 1; in_data = 16'h5A5A;
        in_valid3 = 1; in_sel3 = 3;
        step();
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0000", out_valid);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", out_data);
        end
        n_checks++;
        if (drop_cnt !== 8'd0 || drop_cnt3 !== 8'd0) begin
            n_fail++; $display("FAIL reset_drop: got %0d/%0d expected 0", drop_cnt, drop_cnt3);
        end
        n_checks++;
        if (out_valid3 !== 3'b000) begin
            n_fail++; $display("FAIL reset_valid3: got %b expected 000", out_valid3);
        end
        idle_inputs();
        rst_n = 1;
        #1;
    endtask

    task automatic test_unicast();
        in_valid = 1; in_sel = 2; in_data = 16'hBEEF; out_ready = 0;
        step();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 4'b0100 || ch(2) !== 16'hBEEF) begin
            n_fail++; $display("FAIL unicast_first: got v=%b d=%h expected v=0100 d=beef", out_valid, ch(2));
        end
        in_valid = 1; in_data = 16'hCAFE;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL unicast_stall_ready: got %b expected 0", in_ready);
        end
        step();
        n_checks++;
        if (ch(2) !== 16'hBEEF || out_valid !== 4'b0100) begin
            n_fail++; $display("FAIL unicast_hold: got v=%b d=%h expected v=0100 d=beef", out_valid, ch(2));
        end
        out_ready = 4'b0100;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL unicast_drain_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 0; out_ready = 0;
        n_checks++;
        if (out_valid !== 4'b0100 || ch(2) !== 16'hCAFE) begin
            n_fail++; $display("FAIL unicast_replace: got v=%b d=%h expected v=0100 d=cafe", out_valid, ch(2));
        end
        out_ready = 4'b0100;
        step();
        out_ready = 0;
        n_checks++;
        if (out_valid !== 4'b0000 || out_data !== '0) begin
            n_fail++; $display("FAIL unicast_drain: got v=%b d=%h expected v=0000 d=0", out_valid, out_data);
        end
    endtask

    task automatic test_broadcast();
        in_valid = 1; in_sel = 1; in_data = 16'h1111; out_ready = 0;
        step();
        in_bc = 1; in_sel = 2; in_data = 16'h1234;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bcast_blocked_ready: got %b expected 0", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0010 || ch(1) !== 16'h1111) begin
            n_fail++; $display("FAIL bcast_no_partial: got v=%b d1=%h expected v=0010 d1=1111", out_valid, ch(1));
        end
        out_ready = 4'b0010;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bcast_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 0; in_bc = 0; out_ready = 0;
        n_checks++;
        if (out_valid !== 4'b1111 || out_data !== {4{16'h1234}}) begin
            n_fail++; $display("FAIL bcast_all: got v=%b d=%h expected v=1111 d=1234x4", out_valid, out_data);
        end
        drain_all();
    endtask

    task automatic test_drop();
        bit ready_ok;
        ready_ok = 1'b1;
        in_valid3 = 1; in_sel3 = 3; out_ready3 = 0;
        for (int i = 0; i < 300; i++) begin
            in_data3 = W'(i);
            #1;
            if (in_ready3 !== 1'b1) ready_ok = 1'b0;
            step();
            if (i == 99) begin
                n_checks++;
                if (drop_cnt3 !== 8'd100) begin
                    n_fail++; $display("FAIL drop_count_100: got %0d expected 100", drop_cnt3);
                end
            end
            if (i == 254) begin
                n_checks++;
                if (drop_cnt3 !== 8'd255) begin
                    n_fail++; $display("FAIL drop_count_255: got %0d expected 255", drop_cnt3);
                end
            end
        end
        in_valid3 = 0;
        n_checks++;
        if (!ready_ok) begin
            n_fail++; $display("FAIL drop_ready: got 0 at least once expected 1 throughout");
        end
        n_checks++;
        if (drop_cnt3 !== 8'd255) begin
            n_fail++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt3);
        end
        n_checks++;
        if (out_valid3 !== 3'b000) begin
            n_fail++; $display("FAIL drop_no_valid: got %b expected 000", out_valid3);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        in_valid = 1; in_sel = 1; in_data = 16'hAAAA; out_ready = 0;
        step();
        out_ready = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            c = (i % 2 == 0) ? 0 : 3;
            in_sel = 2'(c);
            in_data = 16'h0100 + W'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready);
            end
            step();
            n_checks++;
            if (out_valid[c] !== 1'b1 || ch(c) !== 16'h0100 + W'(i)) begin
                n_fail++; $display("FAIL b2b_word_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid[c], ch(c), 16'h0100 + W'(i));
            end
            n_checks++;
            if (out_valid[1] !== 1'b1 || ch(1) !== 16'hAAAA) begin
                n_fail++; $display("FAIL b2b_ch1_hold_%0d: got v=%b d=%h expected v=1 d=aaaa", i, out_valid[1], ch(1));
            end
        end
        drain_all();
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_sel = 2'(c); in_data = 16'h7000 + W'(c);
            step();
        end
        in_valid = 0;
        n_checks++;
        if (out_valid !== 4'b0111) begin
            n_fail++; $display("FAIL rmid_prefill: got %b expected 0111", out_valid);
        end
        rst_n = 0;
        in_valid = 1; in_sel = 3; in_data = 16'hDEAD;
        step();
        rst_n = 1;
        in_valid = 0;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || out_data !== '0) begin
            n_fail++; $display("FAIL rmid_clear: got v=%b d=%h expected v=0000 d=0", out_valid, out_data);
        end
        n_checks++;
        if (drop_cnt3 !== 8'd0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rmid_drop: got %0d/%0d expected 0", drop_cnt, drop_cnt3);
        end
    endtask

    task automatic test_random();
        int bad_ready, bad_state;
        bad_ready = 0; bad_state = 0;
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = 1'($urandom);
            in_bc     = ($urandom_range(0, 7) == 0);
            in_sel    = 2'($urandom);
            in_data   = W'($urandom);
            out_ready = NC'($urandom);
            #1;
            n_checks++;
            if (in_ready !== m_ready()) begin
                n_fail++; bad_ready++;
                if (bad_ready <= 5) $display("FAIL rand_ready_%0d: got %b expected %b", i, in_ready, m_ready());
            end
            step();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (out_valid[c] !== m_valid[c] || ch(c) !== m_data[c]) begin
                    n_fail++; bad_state++;
                    if (bad_state <= 5) $display("FAIL rand_ch%0d_%0d: got v=%b d=%h expected v=%b d=%h", c, i, out_valid[c], ch(c), m_valid[c], m_data[c]);
                end
            end
            n_checks++;
            if (int'(drop_cnt) != m_drop) begin
                n_fail++; $display("FAIL rand_drop_%0d: got %0d expected %0d", i, drop_cnt, m_drop);
            end
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 0;
        idle_inputs();
        for (int c = 0; c < NC; c++) begin
            m_valid[c] = 1'b0;
            m_data[c]  = '0;
        end
        m_drop = 0;
        #2;
        test_reset();
        test_unicast();
        test_broadcast();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
